// File: rtl/fpu_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_32_multiplier
//   Combinational IEEE-754 single-precision multiplier.
//   Ports:
//     x, y           operands
//     res            product, round-to-nearest-even
//     overflow_flag  finite operands whose product exceeds the largest normal;
//                    res is a signed infinity
//     underflow_flag nonzero finite operands whose product falls below the
//                    smallest normal; res is a signed zero (no subnormal output)
//   Subnormal inputs are treated as zero. A NaN operand, or inf * 0, gives the
//   canonical quiet NaN. inf * finite gives a signed infinity with no flag.
// -----------------------------------------------------------------------------
module fpu_32_multiplier (
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] res,
  output logic        overflow_flag,
  output logic        underflow_flag
);

  logic        sx, sy, sr;
  logic [7:0]  ex, ey;
  logic [22:0] mx, my;
  logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;

  logic [47:0]        prod;
  logic [22:0]        mant;
  logic               guard, sticky, round_up;
  logic [23:0]        mant_rnd;
  logic signed [9:0]  exp_biased;

  assign sx = x[31];
  assign sy = y[31];
  assign ex = x[30:23];
  assign ey = y[30:23];
  assign mx = x[22:0];
  assign my = y[22:0];
  assign sr = sx ^ sy;

  assign x_zero = (ex == 8'd0);
  assign y_zero = (ey == 8'd0);
  assign x_inf  = (ex == 8'hFF) && (mx == 23'd0);
  assign y_inf  = (ey == 8'hFF) && (my == 23'd0);
  assign x_nan  = (ex == 8'hFF) && (mx != 23'd0);
  assign y_nan  = (ey == 8'hFF) && (my != 23'd0);

  always_comb begin
    res            = 32'd0;
    overflow_flag  = 1'b0;
    underflow_flag = 1'b0;

    // Product of two 1.x significands lies in [1,4): bit 47 set means [2,4).
    prod       = 48'({1'b1, mx}) * 48'({1'b1, my});
    exp_biased = $signed({2'b00, ex}) + $signed({2'b00, ey}) - 10'sd127;

    if (prod[47]) begin
      mant       = prod[46:24];
      guard      = prod[23];
      sticky     = |prod[22:0];
      exp_biased = exp_biased + 10'sd1;
    end else begin
      mant       = prod[45:23];
      guard      = prod[22];
      sticky     = |prod[21:0];
    end

    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {23'd0, round_up};
    // Rounding carry out of an all-ones mantissa bumps the exponent; the
    // mantissa field is already zero in that case.
    if (mant_rnd[23]) begin
      exp_biased = exp_biased + 10'sd1;
    end

    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
      res = 32'h7FC0_0000;
    end else if (x_inf || y_inf) begin
      res = {sr, 8'hFF, 23'd0};
    end else if (x_zero || y_zero) begin
      res = {sr, 31'd0};
    end else if (exp_biased >= 10'sd255) begin
      res           = {sr, 8'hFF, 23'd0};
      overflow_flag = 1'b1;
    end else if (exp_biased <= 10'sd0) begin
      res            = {sr, 31'd0};
      underflow_flag = 1'b1;
    end else begin
      res = {sr, exp_biased[7:0], mant_rnd[22:0]};
    end
  end

endmodule

// -----------------------------------------------------------------------------
// fpu_mul_arbiter
//   Round-robin arbiter that time-shares one combinational fpu_32_multiplier
//   among NUM_REQ requesters. The granted operands are registered and held for
//   MUL_CYCLES cycles (multicycle path through the multiplier), then the result
//   is registered onto a valid/ready response channel.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | waiting for any req_valid; grant and operand capture happen here
//   CALC  | operand regs drive the multiplier, cnt counts down to 0
//   DONE  | rsp_valid high, rsp_* held until rsp_ready
//
//   Ports:
//     clk, rst      clock (rising edge), async active-high reset
//     req_valid     per-requester request
//     req_ready     per-requester grant, one-hot or zero
//     req_x, req_y  packed operands, requester i at [32*i +: 32]
//     rsp_valid     response valid
//     rsp_ready     response consumer ready
//     rsp_id        requester that owns the response
//     rsp_res       product from the multiplier
//     rsp_of/uf     overflow / underflow flags from the multiplier
//     busy          high whenever not IDLE
// -----------------------------------------------------------------------------
module fpu_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MUL_CYCLES = 2,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_x,
  input  logic [32*NUM_REQ-1:0]   req_y,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_res,
  output logic                    rsp_of,
  output logic                    rsp_uf,
  output logic                    busy
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ID_W-1:0]  ptr, ptr_next;
  logic [ID_W-1:0]  winner;
  logic             grant_any;
  logic [31:0]      sel_x, sel_y;

  logic [31:0]      op_x, op_y;
  logic [ID_W-1:0]  op_id;
  logic [CNT_W-1:0] cnt;

  logic             do_grant, do_sample;

  logic [31:0]      mul_res;
  logic             mul_of, mul_uf;

  // Winner search: the second loop (indices at or after ptr) overrides the
  // first (wrapped indices below ptr), and within each loop the descending
  // scan leaves the lowest index. Net effect: first valid index at or after
  // ptr, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    sel_x     = '0;
    sel_y     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (ID_W'(i) < ptr)) begin
        grant_any = 1'b1;
        winner    = ID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (ID_W'(i) >= ptr)) begin
        grant_any = 1'b1;
        winner    = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == winner) begin
        sel_x = req_x[32*i +: 32];
        sel_y = req_y[32*i +: 32];
      end
    end
  end

  assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // req_ready is masked during reset so no grant is advertised that the
  // held-in-reset registers could not accept.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    do_grant   = 1'b0;
    do_sample  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any && !rst) begin
          req_ready[winner] = 1'b1;
          do_grant          = 1'b1;
          state_next        = CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          do_sample  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      op_x    <= '0;
      op_y    <= '0;
      op_id   <= '0;
      cnt     <= '0;
      rsp_id  <= '0;
      rsp_res <= '0;
      rsp_of  <= 1'b0;
      rsp_uf  <= 1'b0;
    end else begin
      if (do_grant) begin
        op_x  <= sel_x;
        op_y  <= sel_y;
        op_id <= winner;
        cnt   <= CNT_W'(MUL_CYCLES - 1);
        ptr   <= ptr_next;
      end else if ((state == CALC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (do_sample) begin
        rsp_id  <= op_id;
        rsp_res <= mul_res;
        rsp_of  <= mul_of;
        rsp_uf  <= mul_uf;
      end
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  fpu_32_multiplier u_mul (
    .x              (op_x),
    .y              (op_y),
    .res            (mul_res),
    .overflow_flag  (mul_of),
    .underflow_flag (mul_uf)
  );

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Testbench for fpu_mul_arbiter (NUM_REQ=4, MUL_CYCLES=2).
// Reference products come from an integer model that treats each operand as
// signed significand * 2^exponent; random operands keep only 11 fraction bits
// so every product is exact and needs no rounding.
module tb_fpu_mul_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int MUL_CYCLES = 2;
  localparam int ID_W       = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_x, req_y;
  logic                  rsp_valid, rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_res;
  logic                  rsp_of, rsp_uf, busy;

  int tests = 0;
  int fails = 0;

  fpu_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_of    (rsp_of),
    .rsp_uf    (rsp_uf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rand_op();
    return {1'($urandom), 8'($urandom_range(254, 1)), 11'($urandom), 12'd0};
  endfunction

  // value = sig * 2^(e - 127 - 11), sig in [2048,4095]
  function automatic void model_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic of, output logic uf);
    longint siga = 2048 + longint'(a[22:12]);
    longint sigb = 2048 + longint'(b[22:12]);
    longint p    = siga * sigb;
    int     e    = int'(a[30:23]) + int'(b[30:23]) - 276;
    int     k    = (p >= 64'd8388608) ? 23 : 22;
    int     fld  = e + k + 127;
    logic   s    = a[31] ^ b[31];
    longint m    = p << (23 - k);
    of = 1'b0;
    uf = 1'b0;
    if (fld >= 255) begin
      r  = {s, 8'hFF, 23'd0};
      of = 1'b1;
    end else if (fld <= 0) begin
      r  = {s, 31'd0};
      uf = 1'b1;
    end else begin
      r = {s, 8'(fld), 23'(m)};
    end
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise req idx in a fresh cycle, report req_ready seen, step past the edge,
  // then drop the request.
  task automatic grant_one(input int idx, input logic [31:0] x, input logic [31:0] y,
                           output logic [NUM_REQ-1:0] seen);
    @(negedge clk);
    req_x[32*idx +: 32] = x;
    req_y[32*idx +: 32] = y;
    req_valid[idx] = 1'b1;
    #1 seen = req_ready;
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget) begin
      @(negedge clk);
      #1 cycles++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    tests++;
    if ({rsp_valid, busy, req_ready, rsp_of, rsp_uf} !== 8'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got v=%b busy=%b rdy=%b of=%b uf=%b, expected all 0",
               rsp_valid, busy, req_ready, rsp_of, rsp_uf);
    end
    tests++;
    if ({rsp_id, rsp_res} !== 34'd0) begin
      fails++;
      $display("FAIL reset_data: got id=%0d res=%h, expected 0/0", rsp_id, rsp_res);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 tests++;
      if ({rsp_valid, busy, req_ready} !== 6'd0) begin
        fails++;
        $display("FAIL idle_after_reset: got v=%b busy=%b rdy=%b, expected 0", rsp_valid, busy, req_ready);
      end
    end
  endtask

  task automatic test_single();
    logic [NUM_REQ-1:0] seen;
    int cyc; bit ok;
    rsp_ready = 1'b0;
    grant_one(0, 32'h4000_0000, 32'h4040_0000, seen);
    tests++;
    if (seen !== 4'b0001) begin
      fails++; $display("FAIL single_grant: got %b expected 0001", seen);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL single_busy: got %b expected 1", busy);
    end
    wait_rsp(10, cyc, ok);
    tests++;
    if (!ok || cyc != MUL_CYCLES + 1) begin
      fails++; $display("FAIL single_latency: got ok=%0d cycles=%0d expected %0d", ok, cyc, MUL_CYCLES + 1);
    end
    tests++;
    if (rsp_res !== 32'h40C0_0000 || rsp_id !== 2'd0 || rsp_of !== 1'b0 || rsp_uf !== 1'b0) begin
      fails++; $display("FAIL single_result: got res=%h id=%0d of=%b uf=%b expected 40c00000 id=0", rsp_res, rsp_id, rsp_of, rsp_uf);
    end
    finish_rsp();
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_release: got v=%b busy=%b expected 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    logic [31:0] cx[NUM_REQ], cy[NUM_REQ];
    int q_id[$];
    logic [31:0] q_res[$];
    logic [1:0] q_fl[$];
    int ng = 0, nr = 0, cyc = 0, last = 0, pend = -1, gidx, eid;
    logic [31:0] er;
    logic eof, euf;
    logic [1:0] efl;
    reset_dut();
    for (int i = 0; i < NUM_REQ; i++) begin
      cx[i] = rand_op(); cy[i] = rand_op();
      req_x[32*i +: 32] = cx[i]; req_y[32*i +: 32] = cy[i];
    end
    rsp_ready = 1'b1;
    while (nr < 6 && cyc < 60) begin
      @(negedge clk);
      if (pend >= 0) begin
        cx[pend] = rand_op(); cy[pend] = rand_op();
        req_x[32*pend +: 32] = cx[pend]; req_y[32*pend +: 32] = cy[pend];
        pend = -1;
      end
      if (cyc == 0) req_valid = 4'hF;
      if (ng == 6) req_valid = 4'h0;
      #1 cyc++;
      if (rsp_valid) begin
        tests++;
        if (q_id.size() == 0) begin
          fails++; $display("FAIL rr_unexpected_rsp: got id=%0d with no grant outstanding", rsp_id);
        end else begin
          eid = q_id.pop_front(); er = q_res.pop_front(); efl = q_fl.pop_front();
          if (int'(rsp_id) != eid || rsp_res !== er || {rsp_of, rsp_uf} !== efl) begin
            fails++;
            $display("FAIL rr_rsp: got id=%0d res=%h of/uf=%b expected id=%0d res=%h of/uf=%b",
                     rsp_id, rsp_res, {rsp_of, rsp_uf}, eid, er, efl);
          end
        end
        nr++;
      end
      if (req_ready != '0) begin
        gidx = 0;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gidx = i;
        tests++;
        if (ng >= 6) begin
          fails++; $display("FAIL rr_extra_grant: got %b expected no grant", req_ready);
        end else if (req_ready !== 4'(1 << exp_order[ng])) begin
          fails++; $display("FAIL rr_order: got %b expected %b", req_ready, 4'(1 << exp_order[ng]));
        end
        if (ng > 0) begin
          tests++;
          if (cyc - last != MUL_CYCLES + 2) begin
            fails++; $display("FAIL rr_interval: got %0d cycles expected %0d", cyc - last, MUL_CYCLES + 2);
          end
        end
        model_mul(cx[gidx], cy[gidx], er, eof, euf);
        q_id.push_back(gidx); q_res.push_back(er); q_fl.push_back({eof, euf});
        pend = gidx; last = cyc; ng++;
      end
    end
    tests++;
    if (nr != 6) begin
      fails++; $display("FAIL rr_timeout: got %0d responses expected 6", nr);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [NUM_REQ-1:0] seen;
    logic [31:0] x, y, er, r0;
    logic eof, euf;
    logic [ID_W-1:0] id0;
    int cyc; bit ok;
    x = rand_op(); y = rand_op();
    model_mul(x, y, er, eof, euf);
    grant_one(1, x, y, seen);
    tests++;
    if (seen !== 4'b0010) begin
      fails++; $display("FAIL bp_grant: got %b expected 0010", seen);
    end
    wait_rsp(10, cyc, ok);
    tests++;
    if (!ok || rsp_res !== er || rsp_id !== 2'd1 || {rsp_of, rsp_uf} !== {eof, euf}) begin
      fails++; $display("FAIL bp_result: got ok=%0d res=%h id=%0d expected res=%h id=1", ok, rsp_res, rsp_id, er);
    end
    r0 = rsp_res; id0 = rsp_id;
    req_x[64 +: 32] = rand_op(); req_y[64 +: 32] = rand_op();
    req_valid[2] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1 tests++;
      if (rsp_valid !== 1'b1 || rsp_res !== r0 || rsp_id !== id0 || req_ready !== 4'b0000) begin
        fails++; $display("FAIL bp_hold: got v=%b res=%h id=%0d rdy=%b expected v=1 res=%h id=%0d rdy=0000",
                          rsp_valid, rsp_res, rsp_id, req_ready, r0, id0);
      end
    end
    rsp_ready = 1'b1;
    #1 tests++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL bp_handshake_cycle: got rdy=%b expected 0000", req_ready);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++; $display("FAIL bp_next_grant: got rdy=%b expected 0100", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(10, cyc, ok);
    tests++;
    if (!ok || rsp_id !== 2'd2) begin
      fails++; $display("FAIL bp_second_rsp: got ok=%0d id=%0d expected id=2", ok, rsp_id);
    end
    finish_rsp();
  endtask

  task automatic test_flags();
    logic [31:0] xs[4] = '{32'hC2FC_0000, 32'h0E00_0000, 32'h7E80_0000, 32'h3FC0_0001};
    logic [31:0] ys[4] = '{32'h42FE_0000, 32'h0E00_0000, 32'h7E80_0000, 32'h3FC0_0001};
    logic [31:0] rs[4] = '{32'hC67A_0800, 32'h0000_0000, 32'h7F80_0000, 32'h4010_0002};
    logic [1:0]  fs[4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    logic [NUM_REQ-1:0] seen;
    int cyc; bit ok;
    for (int i = 0; i < 4; i++) begin
      grant_one(2, xs[i], ys[i], seen);
      wait_rsp(10, cyc, ok);
      tests++;
      if (!ok || seen !== 4'b0100 || rsp_res !== rs[i] || {rsp_of, rsp_uf} !== fs[i] || rsp_id !== 2'd2) begin
        fails++; $display("FAIL flags_case%0d: got ok=%0d rdy=%b res=%h of/uf=%b id=%0d expected res=%h of/uf=%b id=2",
                          i, ok, seen, rsp_res, {rsp_of, rsp_uf}, rsp_id, rs[i], fs[i]);
      end
      finish_rsp();
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] seen;
    logic [31:0] x, y, er;
    logic eof, euf;
    int idx, cyc, d; bit ok;
    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(NUM_REQ - 1, 0);
      x = rand_op(); y = rand_op();
      model_mul(x, y, er, eof, euf);
      grant_one(idx, x, y, seen);
      tests++;
      if (seen !== 4'(1 << idx)) begin
        fails++; $display("FAIL rand_grant: got %b expected %b", seen, 4'(1 << idx));
      end
      wait_rsp(10, cyc, ok);
      tests++;
      if (!ok || cyc != MUL_CYCLES + 1 || int'(rsp_id) != idx || rsp_res !== er || {rsp_of, rsp_uf} !== {eof, euf}) begin
        fails++; $display("FAIL rand_rsp: x=%h y=%h got ok=%0d lat=%0d id=%0d res=%h of/uf=%b expected id=%0d res=%h of/uf=%b",
                          x, y, ok, cyc, rsp_id, rsp_res, {rsp_of, rsp_uf}, idx, er, {eof, euf});
      end
      d = $urandom_range(3, 0);
      repeat (d) begin
        @(negedge clk);
        #1 tests++;
        if (rsp_valid !== 1'b1 || rsp_res !== er) begin
          fails++; $display("FAIL rand_hold: got v=%b res=%h expected v=1 res=%h", rsp_valid, rsp_res, er);
        end
      end
      finish_rsp();
      tests++;
      if (rsp_valid !== 1'b0) begin
        fails++; $display("FAIL rand_release: got v=%b expected 0", rsp_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    int victims[2] = '{3, 1};
    logic [NUM_REQ-1:0] seen;
    logic [31:0] x, y, er;
    logic eof, euf;
    int cyc; bit ok, quiet;
    for (int v = 0; v < 2; v++) begin
      grant_one(victims[v], rand_op(), rand_op(), seen);
      @(negedge clk);
      rst = 1'b1;
      #1 tests++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
        fails++; $display("FAIL midrst_abort: got busy=%b v=%b expected 0/0", busy, rsp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      quiet = 1'b1;
      repeat (6) begin
        @(negedge clk);
        #1 if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      tests++;
      if (!quiet) begin
        fails++; $display("FAIL midrst_no_rsp: got a response or busy after reset, expected none");
      end
      @(negedge clk);
      x = rand_op(); y = rand_op();
      model_mul(x, y, er, eof, euf);
      req_x[32 +: 32] = x; req_y[32 +: 32] = y;
      req_x[96 +: 32] = rand_op(); req_y[96 +: 32] = rand_op();
      req_valid = 4'b1010;
      #1 tests++;
      if (req_ready !== 4'b0010) begin
        fails++; $display("FAIL midrst_grant: got %b expected 0010", req_ready);
      end
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(10, cyc, ok);
      tests++;
      if (!ok || rsp_id !== 2'd1 || rsp_res !== er) begin
        fails++; $display("FAIL midrst_rsp: got ok=%0d id=%0d res=%h expected id=1 res=%h", ok, rsp_id, rsp_res, er);
      end
      finish_rsp();
    end
  endtask

  task automatic test_operand_change();
    logic [NUM_REQ-1:0] seen;
    logic [31:0] x, y, er;
    logic eof, euf;
    int cyc; bit ok;
    for (int n = 0; n < 3; n++) begin
      x = rand_op(); y = rand_op();
      model_mul(x, y, er, eof, euf);
      grant_one(0, x, y, seen);
      req_x[31:0] = ~x;
      req_y[31:0] = rand_op();
      @(negedge clk);
      req_x[31:0] = rand_op();
      wait_rsp(10, cyc, ok);
      tests++;
      if (!ok || rsp_res !== er || {rsp_of, rsp_uf} !== {eof, euf}) begin
        fails++; $display("FAIL opchange_rsp: got ok=%0d res=%h expected res=%h", ok, rsp_res, er);
      end
      finish_rsp();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flags();
    test_random();
    test_reset_mid();
    test_operand_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
